// File: rtl/word_sequencer.sv
// Character-index sequencer feeding the per-word character ROMs.
// Steps a 4-bit index once per display period and pulses strobes for the display stage.
module word_sequencer #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned DIV_W    = 26,
  parameter int unsigned MAX_LEN  = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       enable,
  input  logic       loop_mode,
  input  logic [3:0] len_string,
  output logic [3:0] counter_caracter,
  output logic       char_strobe,
  output logic       word_done,
  output logic       busy
);

  localparam int unsigned IDX_W = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] LEN_MAX  = IDX_W'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_len;
  logic [DIV_W-1:0]   r_presc;
  logic               r_char_strobe;
  logic               r_word_done;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [IDX_W-1:0]   w_len_nxt;
  logic [DIV_W-1:0]   w_presc_nxt;
  logic               w_char_strobe_nxt;
  logic               w_word_done_nxt;
  logic               w_busy_nxt;
  logic               w_start_ok;
  logic               w_tick;
  logic [IDX_W-1:0]   w_len_clamp;
  logic [IDX_W-1:0]   w_last_idx;

  assign w_start_ok  = start && (len_string != '0);
  assign w_tick      = (r_state == SHOW) && enable && (r_presc == DIV_LAST);
  assign w_len_clamp = (len_string > LEN_MAX) ? LEN_MAX : len_string;
  assign w_last_idx  = r_len - IDX_W'(1);

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_len         <= '0;
      r_presc       <= '0;
      r_char_strobe <= 1'b0;
      r_word_done   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_len         <= w_len_nxt;
      r_presc       <= w_presc_nxt;
      r_char_strobe <= w_char_strobe_nxt;
      r_word_done   <= w_word_done_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  // Next-state logic; a valid start overrides any tick in the same cycle
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_len_nxt         = r_len;
    w_presc_nxt       = r_presc;
    w_char_strobe_nxt = 1'b0;
    w_word_done_nxt   = 1'b0;

    if (w_start_ok) begin
      w_state_nxt       = SHOW;
      w_len_nxt         = w_len_clamp;
      w_idx_nxt         = '0;
      w_presc_nxt       = '0;
      w_char_strobe_nxt = 1'b1;
    end else begin
      case (r_state)
        SHOW: begin
          if (w_tick) begin
            w_presc_nxt = '0;
            if (r_idx < w_last_idx) begin
              w_idx_nxt         = r_idx + IDX_W'(1);
              w_char_strobe_nxt = 1'b1;
            end else begin
              w_word_done_nxt = 1'b1;
              if (loop_mode) begin
                w_idx_nxt         = '0;
                w_char_strobe_nxt = 1'b1;
              end else begin
                w_state_nxt = DONE;
              end
            end
          end else if (enable) begin
            w_presc_nxt = r_presc + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end

    w_busy_nxt = (w_state_nxt == SHOW);
  end

  assign counter_caracter = r_idx;
  assign char_strobe      = r_char_strobe;
  assign word_done        = r_word_done;
  assign busy             = r_busy;

endmodule

// File: tb/tb_word_sequencer.sv
// Self-checking bench for word_sequencer with TICK_DIV=4.
// Expected char_strobe indices are queued by each test and popped by a strobe monitor.
module tb_word_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       enable = 1'b0;
  logic       loop_mode = 1'b0;
  logic [3:0] len_string = 4'd0;
  logic [3:0] counter_caracter;
  logic       char_strobe;
  logic       word_done;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  word_sequencer #(.TICK_DIV(4), .DIV_W(3), .MAX_LEN(12)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .enable(enable),
    .loop_mode(loop_mode),
    .len_string(len_string),
    .counter_caracter(counter_caracter),
    .char_strobe(char_strobe),
    .word_done(word_done),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Strobe monitor: every char_strobe must match the next queued index
  always @(negedge clock) begin
    if (!reset && char_strobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected idx=%0d", counter_caracter);
      end else begin
        mon_exp = exp_q.pop_front();
        if (counter_caracter !== mon_exp) begin
          errors++;
          $display("FAIL strobe_idx got=%0d exp=%0d", counter_caracter, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic drain_check(input string name);
    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got=%0d exp=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks += 4;
    if (counter_caracter !== 4'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", counter_caracter); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    if (char_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%0b exp=0", char_strobe); end
    if (word_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", word_done); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_pass();
    int e;
    len_string = 4'd11; loop_mode = 1'b0; enable = 1'b1;
    for (int i = 0; i <= 10; i++) exp_q.push_back(4'(i));
    pulse_start();
    checks += 2;
    if (counter_caracter !== 4'd0) begin errors++; $display("FAIL single_start_idx got=%0d exp=0", counter_caracter); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_start_busy got=%0b exp=1", busy); end
    for (int k = 1; k <= 60; k++) begin
      step();
      e = (k / 4 > 10) ? 10 : k / 4;
      checks += 3;
      if (counter_caracter !== 4'(e)) begin errors++; $display("FAIL single_idx k=%0d got=%0d exp=%0d", k, counter_caracter, e); end
      if (word_done !== (k == 44)) begin errors++; $display("FAIL single_done k=%0d got=%0b exp=%0b", k, word_done, k == 44); end
      if (busy !== (k < 44)) begin errors++; $display("FAIL single_busy k=%0d got=%0b exp=%0b", k, busy, k < 44); end
    end
    drain_check("single");
  endtask

  task automatic test_loop();
    int e;
    do_reset();
    len_string = 4'd11; loop_mode = 1'b1; enable = 1'b1;
    exp_q.push_back(4'd0);
    for (int k = 4; k <= 100; k += 4) exp_q.push_back(4'((k / 4) % 11));
    pulse_start();
    for (int k = 1; k <= 100; k++) begin
      step();
      e = (k / 4) % 11;
      checks += 4;
      if (counter_caracter !== 4'(e)) begin errors++; $display("FAIL loop_idx k=%0d got=%0d exp=%0d", k, counter_caracter, e); end
      if (word_done !== (k % 44 == 0)) begin errors++; $display("FAIL loop_done k=%0d got=%0b exp=%0b", k, word_done, k % 44 == 0); end
      if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy k=%0d got=%0b exp=1", k, busy); end
      if (counter_caracter > 4'd10) begin errors++; $display("FAIL loop_range k=%0d got=%0d exp<=10", k, counter_caracter); end
    end
    drain_check("loop");
  endtask

  task automatic test_pause();
    do_reset();
    len_string = 4'd11; loop_mode = 1'b0; enable = 1'b1;
    for (int i = 0; i <= 4; i++) exp_q.push_back(4'(i));
    pulse_start();
    repeat (12) step();
    checks++;
    if (counter_caracter !== 4'd3) begin errors++; $display("FAIL pause_at3 got=%0d exp=3", counter_caracter); end
    repeat (2) step();
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      checks += 2;
      if (counter_caracter !== 4'd3) begin errors++; $display("FAIL pause_hold k=%0d got=%0d exp=3", k, counter_caracter); end
      if (char_strobe !== 1'b0) begin errors++; $display("FAIL pause_strobe k=%0d got=%0b exp=0", k, char_strobe); end
    end
    enable = 1'b1;
    step();
    checks++;
    if (counter_caracter !== 4'd3) begin errors++; $display("FAIL pause_resume1 got=%0d exp=3", counter_caracter); end
    step();
    checks += 2;
    if (counter_caracter !== 4'd4) begin errors++; $display("FAIL pause_resume2 got=%0d exp=4", counter_caracter); end
    if (char_strobe !== 1'b1) begin errors++; $display("FAIL pause_resume_strobe got=%0b exp=1", char_strobe); end
    drain_check("pause");
  endtask

  task automatic test_lengths();
    do_reset();
    // Length change mid-word is ignored
    len_string = 4'd11; loop_mode = 1'b0; enable = 1'b1;
    for (int i = 0; i <= 10; i++) exp_q.push_back(4'(i));
    pulse_start();
    for (int k = 1; k <= 46; k++) begin
      step();
      if (k == 24) len_string = 4'd5;
      if (k == 40) begin
        checks++;
        if (counter_caracter !== 4'd10) begin errors++; $display("FAIL len_change_idx got=%0d exp=10", counter_caracter); end
      end
      if (k == 44) begin
        checks++;
        if (word_done !== 1'b1) begin errors++; $display("FAIL len_change_done got=%0b exp=1", word_done); end
      end
    end
    drain_check("len_change");
    // Zero length start is ignored in DONE
    len_string = 4'd0;
    pulse_start();
    step();
    checks += 3;
    if (counter_caracter !== 4'd10) begin errors++; $display("FAIL len0_idx got=%0d exp=10", counter_caracter); end
    if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy got=%0b exp=0", busy); end
    if (char_strobe !== 1'b0) begin errors++; $display("FAIL len0_strobe got=%0b exp=0", char_strobe); end
    // Oversized length clamps to MAX_LEN
    len_string = 4'd15;
    for (int i = 0; i <= 11; i++) exp_q.push_back(4'(i));
    pulse_start();
    for (int k = 1; k <= 52; k++) begin
      step();
      if (k == 44 || k == 52) begin
        checks += 2;
        if (counter_caracter !== 4'd11) begin errors++; $display("FAIL len15_idx k=%0d got=%0d exp=11", k, counter_caracter); end
        if (busy !== (k == 44)) begin errors++; $display("FAIL len15_busy k=%0d got=%0b exp=%0b", k, busy, k == 44); end
      end
      if (k == 48) begin
        checks++;
        if (word_done !== 1'b1) begin errors++; $display("FAIL len15_done got=%0b exp=1", word_done); end
      end
    end
    drain_check("len15");
    // Start coincident with the last-index tick
    do_reset();
    len_string = 4'd3; loop_mode = 1'b1;
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd0);
    pulse_start();
    repeat (11) step();
    checks++;
    if (counter_caracter !== 4'd2) begin errors++; $display("FAIL coincide_pre got=%0d exp=2", counter_caracter); end
    pulse_start();
    checks += 4;
    if (counter_caracter !== 4'd0) begin errors++; $display("FAIL coincide_idx got=%0d exp=0", counter_caracter); end
    if (char_strobe !== 1'b1) begin errors++; $display("FAIL coincide_strobe got=%0b exp=1", char_strobe); end
    if (word_done !== 1'b0) begin errors++; $display("FAIL coincide_done got=%0b exp=0", word_done); end
    if (busy !== 1'b1) begin errors++; $display("FAIL coincide_busy got=%0b exp=1", busy); end
    drain_check("coincide");
  endtask

  task automatic test_async_reset();
    do_reset();
    len_string = 4'd11; loop_mode = 1'b0; enable = 1'b1;
    for (int i = 0; i <= 7; i++) exp_q.push_back(4'(i));
    pulse_start();
    repeat (28) step();
    checks++;
    if (counter_caracter !== 4'd7) begin errors++; $display("FAIL areset_pre got=%0d exp=7", counter_caracter); end
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    checks += 3;
    if (counter_caracter !== 4'd0) begin errors++; $display("FAIL areset_idx got=%0d exp=0", counter_caracter); end
    if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%0b exp=0", busy); end
    if (char_strobe !== 1'b0) begin errors++; $display("FAIL areset_strobe got=%0b exp=0", char_strobe); end
    #1 reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks += 2;
      if (counter_caracter !== 4'd0) begin errors++; $display("FAIL areset_idle_idx k=%0d got=%0d exp=0", k, counter_caracter); end
      if (busy !== 1'b0) begin errors++; $display("FAIL areset_idle_busy k=%0d got=%0b exp=0", k, busy); end
    end
    drain_check("areset");
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_loop();
    test_pause();
    test_lengths();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
